// File: rtl/fifo_async_rd_packer_if.sv
// rtl/fifo_async_rd_packer_if.sv - FIFO pop port, flush control and packed beat stream of the read-side packer
interface fifo_async_rd_packer_if #(
    parameter int W = 32,
    parameter int K = 4
);
    logic             fifo_empty_r;
    logic [W-1:0]     fifo_pop_data;
    logic             fifo_pop;
    logic             flush;
    logic             out_ready;
    logic             out_valid_r;
    logic [W*K-1:0]   out_data_r;
    logic [K-1:0]     out_mask_r;
    logic             flush_done_r;
    logic             busy;

    // Environment side: owns the FIFO head, flush request and downstream ready
    modport master (
        output fifo_empty_r, fifo_pop_data, flush, out_ready,
        input  fifo_pop, out_valid_r, out_data_r, out_mask_r, flush_done_r, busy
    );

    // Packer side
    modport slave (
        input  fifo_empty_r, fifo_pop_data, flush, out_ready,
        output fifo_pop, out_valid_r, out_data_r, out_mask_r, flush_done_r, busy
    );
endinterface

// File: rtl/fifo_async_rd_packer.sv
// rtl/fifo_async_rd_packer.sv - packs K FIFO words per output beat with flush-driven partial beats
module fifo_async_rd_packer #(
    parameter int W     = 32,
    parameter int K     = 4,
    parameter int CNT_W = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_async_rd_packer_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } flush_state_t;

    localparam logic [CNT_W-1:0] CNT_K    = CNT_W'(K);
    localparam logic [CNT_W-1:0] CNT_KM1  = CNT_W'(K - 1);
    localparam logic [K-1:0]     MASK_ALL = {K{1'b1}};

    flush_state_t       state_r;
    flush_state_t       state_nxt;
    logic [CNT_W-1:0]   acc_cnt_r;
    logic [CNT_W-1:0]   acc_cnt_nxt;
    logic [W-1:0]       acc_r [K];

    logic               out_valid_r;
    logic [W*K-1:0]     out_data_r;
    logic [K-1:0]       out_mask_r;
    logic               flush_done_r;

    logic               flush_pend_r;
    logic               can_load;
    logic               fpend;
    logic               pop;
    logic               load;
    logic               wr_en;
    logic [CNT_W-1:0]   wr_lane;
    logic               done_nxt;
    logic [W*K-1:0]     acc_flat;
    logic [K-1:0]       cnt_mask;
    logic [W*K-1:0]     load_data;
    logic [K-1:0]       load_mask;

    assign flush_pend_r = (state_r == PEND);
    assign can_load     = ~out_valid_r | bus.out_ready;
    assign fpend        = bus.flush | flush_pend_r;
    // Gated by rst_n so the FIFO never sees a pop while the packer is held in reset
    assign pop          = rst_n & ~bus.fifo_empty_r & ~fpend
                        & ((acc_cnt_r < CNT_K) | can_load);

    // Flatten the accumulator; lanes at or above the fill count read as zero
    always_comb begin
        acc_flat = '0;
        cnt_mask = '0;
        for (int i = 0; i < K; i++) begin
            if (CNT_W'(i) < acc_cnt_r) begin
                acc_flat[i*W +: W] = acc_r[i];
                cnt_mask[i]        = 1'b1;
            end
        end
    end

    // Flush FSM next state plus accumulator/output load decisions
    always_comb begin
        state_nxt   = state_r;
        acc_cnt_nxt = acc_cnt_r;
        load        = 1'b0;
        load_data   = acc_flat;
        load_mask   = cnt_mask;
        wr_en       = 1'b0;
        wr_lane     = acc_cnt_r;
        done_nxt    = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.flush) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (acc_cnt_r == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (can_load) begin
                    load        = 1'b1;
                    acc_cnt_nxt = '0;
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A full accumulator parked behind a stalled output drains as soon as the output frees up
        if (acc_cnt_r == CNT_K && can_load) begin
            load        = 1'b1;
            acc_cnt_nxt = '0;
        end

        if (pop) begin
            if (acc_cnt_r == CNT_K) begin
                // Accumulator unloads this cycle, so the new word starts the next beat
                wr_en       = 1'b1;
                wr_lane     = '0;
                acc_cnt_nxt = CNT_W'(1);
            end else if (acc_cnt_r == CNT_KM1 && can_load) begin
                // Final word bypasses the accumulator straight into the output register
                load                        = 1'b1;
                load_data[(K-1)*W +: W]     = bus.fifo_pop_data;
                load_mask                   = MASK_ALL;
                acc_cnt_nxt                 = '0;
            end else begin
                wr_en       = 1'b1;
                acc_cnt_nxt = acc_cnt_r + 1'b1;
            end
        end
    end

    // Flush FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Accumulator lanes and fill count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_r <= '0;
            for (int i = 0; i < K; i++) begin
                acc_r[i] <= '0;
            end
        end else begin
            acc_cnt_r <= acc_cnt_nxt;
            for (int i = 0; i < K; i++) begin
                if (wr_en && wr_lane == CNT_W'(i)) begin
                    acc_r[i] <= bus.fifo_pop_data;
                end
            end
        end
    end

    // Output beat register; data and mask only change on a load so they hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_mask_r   <= '0;
            flush_done_r <= 1'b0;
        end else begin
            flush_done_r <= done_nxt;
            if (load) begin
                out_valid_r <= 1'b1;
                out_data_r  <= load_data;
                out_mask_r  <= load_mask;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.fifo_pop     = pop;
    assign bus.out_valid_r  = out_valid_r;
    assign bus.out_data_r   = out_data_r;
    assign bus.out_mask_r   = out_mask_r;
    assign bus.flush_done_r = flush_done_r;
    assign bus.busy         = (acc_cnt_r != '0) | out_valid_r | flush_pend_r;
endmodule

// File: tb/tb_fifo_async_rd_packer.sv
// tb/tb_fifo_async_rd_packer.sv - directed self-checking bench for fifo_async_rd_packer
module tb_fifo_async_rd_packer;
    localparam int W = 32;
    localparam int K = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fifo_async_rd_packer_if #(.W(W), .K(K)) ifc ();

    fifo_async_rd_packer #(.W(W), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    logic [W-1:0]   mem [128];
    int             n_words = 0;
    int             rd_idx = 0;
    int             pop_cnt = 0;
    int             done_cnt = 0;
    logic [W*K-1:0] beat_data [$];
    logic [K-1:0]   beat_mask [$];
    int             n_cmp = 0;
    int             n_bad = 0;

    assign ifc.fifo_empty_r  = (rd_idx >= n_words);
    assign ifc.fifo_pop_data = mem[rd_idx[6:0]];

    // FIFO head advance, beat capture on handshake, flush_done pulse count
    always @(posedge clk) begin
        if (ifc.fifo_pop) begin
            rd_idx  <= rd_idx + 1;
            pop_cnt <= pop_cnt + 1;
        end
        if (ifc.out_valid_r && ifc.out_ready) begin
            beat_data.push_back(ifc.out_data_r);
            beat_mask.push_back(ifc.out_mask_r);
        end
        if (ifc.flush_done_r) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic push(input logic [W-1:0] w);
        mem[n_words[6:0]] = w;
        n_words = n_words + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.flush = 1'b0;
        ifc.out_ready = 1'b0;
        tick(3);
        n_cmp++; if (ifc.out_valid_r !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ifc.out_valid_r); end
        n_cmp++; if (ifc.out_data_r !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", ifc.out_data_r); end
        n_cmp++; if (ifc.out_mask_r !== 4'h0) begin n_bad++; $display("FAIL reset_mask: got %h want 0", ifc.out_mask_r); end
        n_cmp++; if (ifc.flush_done_r !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", ifc.flush_done_r); end
        n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
        n_cmp++; if (ifc.fifo_pop !== 1'b0) begin n_bad++; $display("FAIL reset_pop: got %b want 0", ifc.fifo_pop); end
        rst_n = 1'b1;
        tick(2);
        n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", ifc.busy); end
    endtask

    task automatic test_stream();
        int b0;
        int p0;
        ifc.out_ready = 1'b1;
        b0 = beat_data.size();
        p0 = pop_cnt;
        for (int v = 1; v <= 8; v++) push(v);
        #1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (ifc.fifo_pop !== 1'b1) begin n_bad++; $display("FAIL stream_pop[%0d]: got %b want 1", i, ifc.fifo_pop); end
            @(negedge clk);
            if (i == 3) begin
                n_cmp++; if (ifc.out_valid_r !== 1'b1) begin n_bad++; $display("FAIL stream_latency: got %b want 1", ifc.out_valid_r); end
                n_cmp++; if (ifc.out_mask_r !== 4'hF) begin n_bad++; $display("FAIL stream_mask0: got %h want f", ifc.out_mask_r); end
            end
        end
        n_cmp++; if (ifc.fifo_pop !== 1'b0) begin n_bad++; $display("FAIL stream_pop_end: got %b want 0", ifc.fifo_pop); end
        tick(3);
        n_cmp++; if (pop_cnt - p0 !== 8) begin n_bad++; $display("FAIL stream_pops: got %0d want 8", pop_cnt - p0); end
        n_cmp++; if (beat_data.size() - b0 !== 2) begin n_bad++; $display("FAIL stream_beats: got %0d want 2", beat_data.size() - b0); end
        if (beat_data.size() >= b0 + 2) begin
            n_cmp++; if (beat_data[b0] !== 128'h00000004_00000003_00000002_00000001) begin n_bad++; $display("FAIL stream_beat0: got %h want 00000004000000030000000200000001", beat_data[b0]); end
            n_cmp++; if (beat_data[b0+1] !== 128'h00000008_00000007_00000006_00000005) begin n_bad++; $display("FAIL stream_beat1: got %h want 00000008000000070000000600000005", beat_data[b0+1]); end
            n_cmp++; if (beat_mask[b0+1] !== 4'hF) begin n_bad++; $display("FAIL stream_mask1: got %h want f", beat_mask[b0+1]); end
        end
    endtask

    task automatic test_backpressure();
        int b0;
        int p0;
        ifc.out_ready = 1'b0;
        b0 = beat_data.size();
        p0 = pop_cnt;
        for (int v = 1; v <= 12; v++) push(v);
        tick(12);
        n_cmp++; if (pop_cnt - p0 !== 8) begin n_bad++; $display("FAIL bp_pops_held: got %0d want 8", pop_cnt - p0); end
        n_cmp++; if (ifc.fifo_pop !== 1'b0) begin n_bad++; $display("FAIL bp_pop_blocked: got %b want 0", ifc.fifo_pop); end
        n_cmp++; if (ifc.out_valid_r !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", ifc.out_valid_r); end
        n_cmp++; if (ifc.out_data_r !== 128'h00000004_00000003_00000002_00000001) begin n_bad++; $display("FAIL bp_hold_data: got %h want 00000004000000030000000200000001", ifc.out_data_r); end
        n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy: got %b want 1", ifc.busy); end
        ifc.out_ready = 1'b1;
        tick(8);
        n_cmp++; if (beat_data.size() - b0 !== 3) begin n_bad++; $display("FAIL bp_beats: got %0d want 3", beat_data.size() - b0); end
        if (beat_data.size() >= b0 + 3) begin
            n_cmp++; if (beat_data[b0] !== 128'h00000004_00000003_00000002_00000001) begin n_bad++; $display("FAIL bp_beat0: got %h", beat_data[b0]); end
            n_cmp++; if (beat_data[b0+1] !== 128'h00000008_00000007_00000006_00000005) begin n_bad++; $display("FAIL bp_beat1: got %h", beat_data[b0+1]); end
            n_cmp++; if (beat_data[b0+2] !== 128'h0000000C_0000000B_0000000A_00000009) begin n_bad++; $display("FAIL bp_beat2: got %h", beat_data[b0+2]); end
        end
        n_cmp++; if (pop_cnt - p0 !== 12) begin n_bad++; $display("FAIL bp_pops_total: got %0d want 12", pop_cnt - p0); end
        n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL bp_idle: got %b want 0", ifc.busy); end
    endtask

    task automatic test_partial_flush();
        int b0;
        int d0;
        ifc.out_ready = 1'b1;
        b0 = beat_data.size();
        d0 = done_cnt;
        push(32'hA);
        push(32'hB);
        push(32'hC);
        tick(5);
        n_cmp++; if (ifc.out_valid_r !== 1'b0) begin n_bad++; $display("FAIL pf_no_beat: got %b want 0", ifc.out_valid_r); end
        n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL pf_busy_acc: got %b want 1", ifc.busy); end
        ifc.flush = 1'b1;
        tick(1);
        ifc.flush = 1'b0;
        n_cmp++; if (ifc.flush_done_r !== 1'b0) begin n_bad++; $display("FAIL pf_done_early: got %b want 0", ifc.flush_done_r); end
        tick(1);
        n_cmp++; if (ifc.out_valid_r !== 1'b1) begin n_bad++; $display("FAIL pf_valid: got %b want 1", ifc.out_valid_r); end
        n_cmp++; if (ifc.out_data_r !== 128'h00000000_0000000C_0000000B_0000000A) begin n_bad++; $display("FAIL pf_data: got %h want 000000000000000c0000000b0000000a", ifc.out_data_r); end
        n_cmp++; if (ifc.out_mask_r !== 4'h7) begin n_bad++; $display("FAIL pf_mask: got %h want 7", ifc.out_mask_r); end
        n_cmp++; if (ifc.flush_done_r !== 1'b1) begin n_bad++; $display("FAIL pf_done: got %b want 1", ifc.flush_done_r); end
        tick(4);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL pf_done_once: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (beat_data.size() - b0 !== 1) begin n_bad++; $display("FAIL pf_beats: got %0d want 1", beat_data.size() - b0); end
    endtask

    task automatic test_flush_empty();
        int b0;
        int d0;
        b0 = beat_data.size();
        d0 = done_cnt;
        ifc.flush = 1'b1;
        tick(1);
        ifc.flush = 1'b0;
        n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL fe_busy_pend: got %b want 1", ifc.busy); end
        n_cmp++; if (ifc.flush_done_r !== 1'b0) begin n_bad++; $display("FAIL fe_done_early: got %b want 0", ifc.flush_done_r); end
        tick(1);
        n_cmp++; if (ifc.flush_done_r !== 1'b1) begin n_bad++; $display("FAIL fe_done: got %b want 1", ifc.flush_done_r); end
        n_cmp++; if (ifc.out_valid_r !== 1'b0) begin n_bad++; $display("FAIL fe_no_beat: got %b want 0", ifc.out_valid_r); end
        tick(1);
        n_cmp++; if (ifc.flush_done_r !== 1'b0) begin n_bad++; $display("FAIL fe_done_pulse: got %b want 0", ifc.flush_done_r); end
        tick(2);
        n_cmp++; if (beat_data.size() - b0 !== 0) begin n_bad++; $display("FAIL fe_beats: got %0d want 0", beat_data.size() - b0); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL fe_done_once: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_flush_held();
        int b0;
        int d0;
        int p0;
        ifc.out_ready = 1'b1;
        b0 = beat_data.size();
        d0 = done_cnt;
        p0 = pop_cnt;
        push(32'h11);
        push(32'h22);
        ifc.flush = 1'b1;
        #1;
        n_cmp++; if (ifc.fifo_pop !== 1'b0) begin n_bad++; $display("FAIL fh_pop_flush: got %b want 0", ifc.fifo_pop); end
        @(negedge clk);
        ifc.flush = 1'b0;
        #1;
        n_cmp++; if (ifc.fifo_pop !== 1'b0) begin n_bad++; $display("FAIL fh_pop_pend: got %b want 0", ifc.fifo_pop); end
        @(negedge clk);
        n_cmp++; if (ifc.flush_done_r !== 1'b1) begin n_bad++; $display("FAIL fh_done: got %b want 1", ifc.flush_done_r); end
        n_cmp++; if (pop_cnt - p0 !== 0) begin n_bad++; $display("FAIL fh_no_pops: got %0d want 0", pop_cnt - p0); end
        n_cmp++; if (ifc.fifo_pop !== 1'b1) begin n_bad++; $display("FAIL fh_pop_resume: got %b want 1", ifc.fifo_pop); end
        tick(4);
        n_cmp++; if (pop_cnt - p0 !== 2) begin n_bad++; $display("FAIL fh_pops: got %0d want 2", pop_cnt - p0); end
        ifc.flush = 1'b1;
        tick(1);
        ifc.flush = 1'b0;
        tick(1);
        n_cmp++; if (ifc.out_data_r !== 128'h00000000_00000000_00000022_00000011) begin n_bad++; $display("FAIL fh_data: got %h want 00000000000000000000002200000011", ifc.out_data_r); end
        n_cmp++; if (ifc.out_mask_r !== 4'h3) begin n_bad++; $display("FAIL fh_mask: got %h want 3", ifc.out_mask_r); end
        tick(3);
        n_cmp++; if (done_cnt - d0 !== 2) begin n_bad++; $display("FAIL fh_done_cnt: got %0d want 2", done_cnt - d0); end
        n_cmp++; if (beat_data.size() - b0 !== 1) begin n_bad++; $display("FAIL fh_beats: got %0d want 1", beat_data.size() - b0); end
    endtask

    task automatic test_back_to_back();
        int b0;
        ifc.out_ready = 1'b0;
        b0 = beat_data.size();
        for (int v = 'h31; v <= 'h37; v++) push(v);
        tick(10);
        n_cmp++; if (ifc.out_data_r !== 128'h00000034_00000033_00000032_00000031) begin n_bad++; $display("FAIL b2b_first: got %h", ifc.out_data_r); end
        push(32'h38);
        ifc.out_ready = 1'b1;
        #1;
        n_cmp++; if (ifc.fifo_pop !== 1'b1) begin n_bad++; $display("FAIL b2b_pop: got %b want 1", ifc.fifo_pop); end
        @(negedge clk);
        n_cmp++; if (ifc.out_valid_r !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_kept: got %b want 1", ifc.out_valid_r); end
        n_cmp++; if (ifc.out_data_r !== 128'h00000038_00000037_00000036_00000035) begin n_bad++; $display("FAIL b2b_second: got %h", ifc.out_data_r); end
        @(negedge clk);
        n_cmp++; if (ifc.out_valid_r !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_clear: got %b want 0", ifc.out_valid_r); end
        tick(2);
        n_cmp++; if (beat_data.size() - b0 !== 2) begin n_bad++; $display("FAIL b2b_beats: got %0d want 2", beat_data.size() - b0); end
        if (beat_data.size() >= b0 + 2) begin
            n_cmp++; if (beat_data[b0] !== 128'h00000034_00000033_00000032_00000031) begin n_bad++; $display("FAIL b2b_beat0: got %h", beat_data[b0]); end
            n_cmp++; if (beat_data[b0+1] !== 128'h00000038_00000037_00000036_00000035) begin n_bad++; $display("FAIL b2b_beat1: got %h", beat_data[b0+1]); end
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        int p0;
        ifc.out_ready = 1'b0;
        for (int v = 'h41; v <= 'h46; v++) push(v);
        tick(10);
        n_cmp++; if (ifc.out_valid_r !== 1'b1) begin n_bad++; $display("FAIL rm_pre_valid: got %b want 1", ifc.out_valid_r); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ifc.out_valid_r !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", ifc.out_valid_r); end
        n_cmp++; if (ifc.out_data_r !== '0) begin n_bad++; $display("FAIL rm_data: got %h want 0", ifc.out_data_r); end
        n_cmp++; if (ifc.out_mask_r !== 4'h0) begin n_bad++; $display("FAIL rm_mask: got %h want 0", ifc.out_mask_r); end
        n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", ifc.busy); end
        @(negedge clk);
        b0 = beat_data.size();
        p0 = pop_cnt;
        for (int v = 'h51; v <= 'h54; v++) push(v);
        ifc.out_ready = 1'b1;
        #1;
        n_cmp++; if (ifc.fifo_pop !== 1'b0) begin n_bad++; $display("FAIL rm_pop_in_reset: got %b want 0", ifc.fifo_pop); end
        tick(3);
        n_cmp++; if (pop_cnt - p0 !== 0) begin n_bad++; $display("FAIL rm_no_pops: got %0d want 0", pop_cnt - p0); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (ifc.fifo_pop !== 1'b1) begin n_bad++; $display("FAIL rm_pop_release: got %b want 1", ifc.fifo_pop); end
        tick(6);
        n_cmp++; if (beat_data.size() - b0 !== 1) begin n_bad++; $display("FAIL rm_beats: got %0d want 1", beat_data.size() - b0); end
        if (beat_data.size() >= b0 + 1) begin
            n_cmp++; if (beat_data[b0] !== 128'h00000054_00000053_00000052_00000051) begin n_bad++; $display("FAIL rm_beat: got %h want 00000054000000530000005200000051", beat_data[b0]); end
            n_cmp++; if (beat_mask[b0] !== 4'hF) begin n_bad++; $display("FAIL rm_beat_mask: got %h want f", beat_mask[b0]); end
        end
    endtask

    initial begin
        ifc.flush = 1'b0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_partial_flush();
        test_flush_empty();
        test_flush_held();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
